cache_system: RTL and testbench

Direct-mapped, read-only cache subsystem: a 4-word-line cache data/tag array, a miss-handling controller and a block-organised main memory, all on one clock. It serves 15-bit word-address read requests and returns 32-bit data. It flags hit/miss and keeps running access and hit counters for hit-rate measurement. It sits between a request generator and the memory model used for cache performance experiments.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/block_memory.sv | 50 +++++
 rtl/cache_system.sv | 120 ++++++++++++
 tb/tb_cache_system.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants, line layout and controller states for the cache subsystem.
package cache_pkg;

    localparam int ADDR_W   = 15;
    localparam int WORD_W   = 32;
    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 10;
    localparam int OFFSET_W = 2;
    localparam int LINES    = 1024;
    localparam int WORDS    = 1 << OFFSET_W;
    localparam int BLOCK_W  = ADDR_W - OFFSET_W;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t [WORDS-1:0] block_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        block_t           data;
    } line_t;

    typedef enum logic [1:0] {
        LOOKUP,
        FETCH,
        FILL,
        RESPOND
    } state_t;

endpackage

// File: rtl/block_memory.sv
// Read-only block memory: returns a 4-word block MEM_LATENCY cycles after a read starts.
module block_memory
    import cache_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read,
    input  logic [BLOCK_W-1:0] block_addr,
    output logic               done,
    output block_t             block_data
);

    logic               busy;
    logic [15:0]        elapsed_q;
    logic [15:0]        elapsed;
    logic [BLOCK_W-1:0] addr_q;
    logic [BLOCK_W-1:0] cur_addr;

    // Latency tracking and block contents; every word holds its own address,
    // so the contents are generated rather than stored.
    always_comb begin
        elapsed  = busy ? elapsed_q : '0;
        done     = (busy || read) && (elapsed == 16'(MEM_LATENCY - 1));
        cur_addr = busy ? addr_q : block_addr;
        for (int unsigned w = 0; w < WORDS; w++) begin
            block_data[w] = word_t'({cur_addr, 2'(w)});
        end
    end

    // Start a read when idle, count cycles while busy, drop busy on done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            elapsed_q <= '0;
            addr_q    <= '0;
        end else if (done) begin
            busy      <= 1'b0;
            elapsed_q <= '0;
        end else if (busy || read) begin
            if (!busy) begin
                addr_q <= block_addr;
            end
            busy      <= 1'b1;
            elapsed_q <= elapsed + 16'd1;
        end
    end

endmodule

// File: rtl/cache_system.sv
// Direct-mapped read-only cache with miss controller, block memory and hit/access counters.
module cache_system
    import cache_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    output logic [WORD_W-1:0] data_out,
    output logic              ready,
    output logic              hit,
    output logic              miss,
    output logic [ADDR_W-1:0] access_count,
    output logic [ADDR_W-1:0] hit_count
);

    state_t              state, state_n;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    block_t              data_mem [LINES];
    logic [BLOCK_W-1:0]  blk_q;
    block_t              fill_q;

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  idx;
    logic [OFFSET_W-1:0] off;
    logic [INDEX_W-1:0]  fill_idx;
    line_t               cur_line;
    logic                mem_read;
    logic                fill_we;
    logic                mem_done;
    block_t              mem_data;

    assign tag      = address[ADDR_W-1 -: TAG_W];
    assign idx      = address[OFFSET_W +: INDEX_W];
    assign off      = address[OFFSET_W-1:0];
    assign fill_idx = blk_q[INDEX_W-1:0];

    block_memory #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .read      (mem_read),
        .block_addr(blk_q),
        .done      (mem_done),
        .block_data(mem_data)
    );

    // Lookup of the line addressed by the current request.
    always_comb begin
        cur_line.valid = valid_q[idx];
        cur_line.tag   = tag_mem[idx];
        cur_line.data  = data_mem[idx];
        hit            = rst && cur_line.valid && (cur_line.tag == tag);
    end

    // Controller next state and handshake outputs.
    always_comb begin
        state_n  = state;
        ready    = 1'b0;
        miss     = 1'b0;
        mem_read = 1'b0;
        fill_we  = 1'b0;
        data_out = '0;
        case (state)
            LOOKUP: begin
                if (hit) begin
                    ready    = 1'b1;
                    data_out = cur_line.data[off];
                end else begin
                    miss    = rst;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                mem_read = 1'b1;
                if (mem_done) state_n = FILL;
            end
            FILL: begin
                fill_we = 1'b1;
                state_n = RESPOND;
            end
            RESPOND: begin
                ready    = rst;
                data_out = rst ? data_mem[fill_idx][off] : '0;
                state_n  = LOOKUP;
            end
            default: state_n = LOOKUP;
        endcase
    end

    // State, valid bits, miss block address and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= LOOKUP;
            valid_q      <= '0;
            blk_q        <= '0;
            access_count <= '0;
            hit_count    <= '0;
        end else begin
            state <= state_n;
            if (state == LOOKUP && !hit) blk_q <= address[ADDR_W-1:OFFSET_W];
            if (fill_we) valid_q[fill_idx] <= 1'b1;
            if (ready) access_count <= access_count + 1'b1;
            if (ready && state == LOOKUP) hit_count <= hit_count + 1'b1;
        end
    end

    // Tag/data storage and the captured fill block; not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_done) fill_q <= mem_data;
        if (fill_we) begin
            tag_mem[fill_idx]  <= blk_q[BLOCK_W-1 -: TAG_W];
            data_mem[fill_idx] <= fill_q;
        end
    end

endmodule

// File: tb/tb_cache_system.sv
// Self-checking bench for cache_system: directed table, sweep, random traffic, reset and wrap cases.
module tb_cache_system;

    localparam int L        = 4;
    localparam int MISS_CYC = 3 + L;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] address;
    logic [31:0] data_out;
    logic        ready, hit, miss;
    logic [14:0] access_count, hit_count;

    cache_system #(.MEM_LATENCY(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .data_out    (data_out),
        .ready       (ready),
        .hit         (hit),
        .miss        (miss),
        .access_count(access_count),
        .hit_count   (hit_count)
    );

    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;

    // Reference model: which block each cache index currently holds, plus counts.
    int cached [1024];
    int m_acc, m_hit;

    typedef struct {
        int addr;
        int exp_hit;
        int exp_acc;
        int exp_hitc;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        ncmp++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) cached[i] = -1;
        m_acc = 0;
        m_hit = 0;
    endtask

    task automatic model_req(input int a, output int exp_hit);
        int blk;
        int ix;
        blk = a / 4;
        ix  = blk % 1024;
        exp_hit = (cached[ix] == blk) ? 1 : 0;
        if (exp_hit == 0) cached[ix] = blk;
        m_acc++;
        if (exp_hit != 0) m_hit++;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the completing edge.
    task automatic req(input int a, output int h, output int m, output int d, output int cyc);
        bit got;
        address = a[14:0];
        cyc = 0; h = -1; m = -1; d = -1; got = 0;
        while (cyc < 200 && !got) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                h = int'(hit);
                m = int'(miss);
            end
            if (ready) begin
                d   = int'(data_out);
                got = 1;
            end
        end
        if (!got) check("req_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_and_check(input int a, output int was_hit);
        int h, m, d, cyc, eh;
        model_req(a, eh);
        req(a, h, m, d, cyc);
        check("hit", h, eh);
        check("miss", m, 1 - eh);
        check("data", d, a);
        check("latency", cyc, eh ? 1 : MISS_CYC);
        check("access_count", int'(access_count), m_acc % 32768);
        check("hit_count", int'(hit_count), m_hit % 32768);
        was_hit = eh;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        vec_t vecs [7];
        int   h, m, d, cyc, eh, wh, misses;

        vecs[0] = '{1024, 0, 1, 0};
        vecs[1] = '{1025, 1, 2, 1};
        vecs[2] = '{1026, 1, 3, 2};
        vecs[3] = '{1027, 1, 4, 3};
        vecs[4] = '{0,    0, 5, 3};
        vecs[5] = '{4096, 0, 6, 3};
        vecs[6] = '{0,    0, 7, 3};

        rst     = 1'b0;
        address = 15'd1024;
        model_reset();
        #2;
        check("rst_ready", int'(ready), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_miss", int'(miss), 0);
        check("rst_data", int'(data_out), 0);
        @(posedge clk);
        #1;
        check("rst_access", int'(access_count), 0);
        check("rst_hits", int'(hit_count), 0);
        rst = 1'b1;

        // Directed table: first miss, same-line hits, then a tag conflict on index 0.
        for (int i = 0; i < 7; i++) begin
            model_req(vecs[i].addr, eh);
            req(vecs[i].addr, h, m, d, cyc);
            check("vec_hit", h, vecs[i].exp_hit);
            check("vec_miss", m, 1 - vecs[i].exp_hit);
            check("vec_data", d, vecs[i].addr);
            check("vec_latency", cyc, vecs[i].exp_hit ? 1 : MISS_CYC);
            check("vec_access", int'(access_count), vecs[i].exp_acc);
            check("vec_hits", int'(hit_count), vecs[i].exp_hitc);
        end

        // Sequential sweep from a clean cache.
        do_reset();
        misses = 0;
        for (int a = 1024; a < 9216; a++) begin
            run_and_check(a, wh);
            if (wh == 0) misses++;
        end
        check("sweep_access", int'(access_count), 8192);
        check("sweep_hits", int'(hit_count), 6144);
        check("sweep_misses", misses, 2048);

        // Random traffic over a small index range to mix hits and conflicts.
        for (int n = 0; n < 400; n++) begin
            int a;
            a = int'($urandom_range(0, 7)) * 4096 + int'($urandom_range(0, 15)) * 4
                + int'($urandom_range(0, 3));
            run_and_check(a, wh);
        end

        // Reset in the middle of a fetch.
        run_and_check(1000, wh);
        address = 15'd2000;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #2;
        check("midrst_ready", int'(ready), 0);
        check("midrst_miss", int'(miss), 0);
        check("midrst_data", int'(data_out), 0);
        check("midrst_access", int'(access_count), 0);
        check("midrst_hits", int'(hit_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_and_check(2000, wh);
        run_and_check(1000, wh);

        // Counter wrap by holding a cached address.
        do_reset();
        run_and_check(5, wh);
        repeat (32767) @(posedge clk);
        #1;
        check("wrap_access", int'(access_count), 0);
        check("wrap_hits", int'(hit_count), 32767);
        @(posedge clk);
        #1;
        check("wrap2_access", int'(access_count), 1);
        check("wrap2_hits", int'(hit_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
